pe_request_queue: RTL
=====================

# pe_request_queue

Request buffer and issue controller directly upstream of the process engine. Accepts hash-table operations (search/insert) from the host side with a valid/ready handshake and holds them in a FIFO. Issues them one per cycle to the engine's `input_valid/opcode/key/wr_data` inputs, honouring the engine's `stall` output and a cap on in-flight operations. Drops NOP opcodes at the door so the engine only sees real work.

## Interface
- `DEPTH`, 16: FIFO entries; power of two, ≥2.
- `MAX_OUTSTANDING`, 8: max issued-but-not-completed operations, ≥1.
- `KEY_WIDTH`, 32: key width.
- `VAL_WIDTH`, 32: write-data width.
- `OPCODE_WIDTH`, 4: opcode width.

Ports:
- `clock`  in  1  single clock, all logic on rising edge.
- `reset`  in  1  synchronous, active-high.
- `in_valid`  in  1  host request valid.
- `in_ready`  out  1  queue can accept (not full).
- `in_opcode`  in  OPCODE_WIDTH  0000 NOP, 0001 search, 0010 insert; others passed through.
- `in_key`  in  KEY_WIDTH  request key.
- `in_wr_data`  in  VAL_WIDTH  insert data.
- `pe_input_valid`  out  1  one-cycle issue strobe to engine.
- `pe_opcode`  out  OPCODE_WIDTH  issued opcode.
- `pe_key`  out  KEY_WIDTH  issued key.
- `pe_wr_data`  out  VAL_WIDTH  issued data.
- `pe_stall`  in  1  engine stall; no issue decision while high.
- `pe_output_valid`  in  1  engine completion strobe, one per operation.
- `occupancy`  out  $clog2(DEPTH+1)  FIFO entry count.
- `outstanding`  out  $clog2(MAX_OUTSTANDING+1)  in-flight operation count.

## Operation
- Enqueue: `in_valid && in_ready && in_opcode != 0` writes {opcode,key,wr_data} at write pointer. NOP with `in_valid` is accepted (consumed) but not stored.
- `in_ready = (occupancy != DEPTH)`, from registered count only; no dependency on `in_valid`.
- Issue decision `go = (occupancy != 0) && !pe_stall && (outstanding < MAX_OUTSTANDING) && !fence_block`. On `go`: head entry popped, registered onto `pe_*`, `pe_input_valid` set for next cycle only.
- When not issuing: `pe_input_valid` = 0, `pe_opcode` = 0, `pe_key`/`pe_wr_data` = 0.
- Pointers are log2(DEPTH) bits and wrap naturally; `occupancy` disambiguates full/empty.
- Occupancy: +1 on store, −1 on pop, unchanged on both or neither.
- Outstanding: +1 on `go`, −1 on `pe_output_valid`, unchanged on both. `pe_output_valid` with outstanding 0 ignored (saturates at 0, no underflow).
- Order strictly FIFO; no reordering.

## Timing
- Reset values: `in_ready` 1 after reset released (0 while `reset` high), `pe_input_valid` 0, `pe_opcode/key/wr_data` 0, `occupancy` 0, `outstanding` 0. FIFO contents discarded; pending completions after reset are ignored via saturation.
- Reset mid-operation: all state cleared on the reset edge; an in-flight `pe_input_valid` drops the next cycle.
- Latency: request accepted at edge k into empty queue with engine idle → `pe_input_valid` high in the cycle after edge k+1 (two edges accept-to-issue).
- Throughput: one issue per cycle sustained while conditions hold; one enqueue per cycle.
- Full queue: `in_ready` low; a pop at edge k raises `in_ready` after edge k.
- Empty with simultaneous enqueue: entry not issuable until next edge (no bypass).
- `pe_stall` sampled the same cycle as the decision; a stall rising after issue does not retract the strobe.

## Configuration
- `PE_RAW_FENCE_EN`: defined → queue records key of last issued insert and a valid flag (cleared when `outstanding` reaches 0). `fence_block` = head is search (0001) with key equal to recorded key while flag set and outstanding ≠ 0; head waits until outstanding drains. Undefined → `fence_block` = 0, no key register.

## Test plan
- Reset: hold `reset` 3 cycles → all outputs at reset values, `occupancy` 0, `in_ready` 1 after release.
- Single insert key 10, data 100, engine idle → `pe_input_valid` one cycle, `pe_opcode` 0010, `pe_key` 10, `pe_wr_data` 100, `outstanding` 1; completion pulse → 0.
- Fill: 16 inserts keys 0..15 with `pe_stall` high → `occupancy` 16, `in_ready` 0; drop stall → issues keys 0..15 in order on 16 consecutive cycles.
- Credit cap: MAX_OUTSTANDING=8, no completions, 10 queued → exactly 8 issues then hold; one `pe_output_valid` → 9th issues next cycle.
- NOP filter: 5 NOPs interleaved with 2 searches → only 2 issues, `occupancy` never exceeds 2.
- With `PE_RAW_FENCE_EN`: insert key 10 then search key 10 → search withheld until completion returns `outstanding` to 0; search key 11 issues back-to-back.

Source files
------------

// File: rtl/pe_request_queue.sv
// ---------------------------------------------------------------------------
// pe_request_queue
//
// Request buffer and issue controller in front of the hash-table process
// engine. Host operations arrive over a valid/ready handshake and are held in
// a FIFO. They are issued to the engine one per cycle, in order. Issue stops
// while the engine stalls or while the in-flight count is at its cap. NOP
// requests are consumed at the input and are never stored.
//
// Optional feature (compile-time macro PE_RAW_FENCE_EN):
//   When this macro is defined, the key of the last issued insert is recorded.
//   A search to that key is held at the head of the queue until every
//   outstanding operation has completed. When the macro is undefined, no key
//   register is built and the head is never fenced.
//
// Ports:
//   clock, reset        single rising-edge clock, synchronous active-high reset
//   in_valid/in_ready   host handshake; in_ready = queue not full
//   in_opcode/key/wr_data  host request (opcode 0 = NOP, 1 = search, 2 = insert)
//   pe_input_valid      one-cycle issue strobe to the engine
//   pe_opcode/key/wr_data  issued request, all zero when not issuing
//   pe_stall            engine stall; no issue decision while high
//   pe_output_valid     engine completion strobe, one per operation
//   occupancy           number of stored FIFO entries
//   outstanding         number of issued, not yet completed operations
// ---------------------------------------------------------------------------
module pe_request_queue #(
   parameter int DEPTH           = 16,
   parameter int MAX_OUTSTANDING = 8,
   parameter int KEY_WIDTH       = 32,
   parameter int VAL_WIDTH       = 32,
   parameter int OPCODE_WIDTH    = 4
) (
   input  logic                                   clock,
   input  logic                                   reset,
   input  logic                                   in_valid,
   output logic                                   in_ready,
   input  logic [OPCODE_WIDTH-1:0]                in_opcode,
   input  logic [KEY_WIDTH-1:0]                   in_key,
   input  logic [VAL_WIDTH-1:0]                   in_wr_data,
   output logic                                   pe_input_valid,
   output logic [OPCODE_WIDTH-1:0]                pe_opcode,
   output logic [KEY_WIDTH-1:0]                   pe_key,
   output logic [VAL_WIDTH-1:0]                   pe_wr_data,
   input  logic                                   pe_stall,
   input  logic                                   pe_output_valid,
   output logic [$clog2(DEPTH+1)-1:0]             occupancy,
   output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);
   localparam int OW = $clog2(MAX_OUTSTANDING+1);
   localparam int EW = OPCODE_WIDTH + KEY_WIDTH + VAL_WIDTH;

   localparam logic [CW-1:0]           FULL_CNT  = CW'(DEPTH);
   localparam logic [OW-1:0]           OUTS_CAP  = OW'(MAX_OUTSTANDING);
   localparam logic [OPCODE_WIDTH-1:0] OP_NOP    = '0;
   localparam logic [OPCODE_WIDTH-1:0] OP_INSERT = OPCODE_WIDTH'(2);

   // Entry layout: {opcode, key, wr_data}
   logic [EW-1:0]           mem_q [DEPTH];
   logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]           count_q, count_d;
   logic [OW-1:0]           outs_q, outs_d;
   logic                    pe_valid_q, pe_valid_d;
   logic [OPCODE_WIDTH-1:0] pe_opcode_q, pe_opcode_d;
   logic [KEY_WIDTH-1:0]    pe_key_q, pe_key_d;
   logic [VAL_WIDTH-1:0]    pe_wr_data_q, pe_wr_data_d;

   logic [EW-1:0]           head;
   logic [OPCODE_WIDTH-1:0] head_opcode;
   logic [KEY_WIDTH-1:0]    head_key;
   logic [VAL_WIDTH-1:0]    head_wr_data;
   logic                    store;
   logic                    go;
   logic                    retire;
   logic                    fence_block;

   assign head         = mem_q[rd_ptr_q];
   assign head_opcode  = head[EW-1 -: OPCODE_WIDTH];
   assign head_key     = head[VAL_WIDTH +: KEY_WIDTH];
   assign head_wr_data = head[VAL_WIDTH-1:0];

`ifdef PE_RAW_FENCE_EN
   localparam logic [OPCODE_WIDTH-1:0] OP_SEARCH = OPCODE_WIDTH'(1);

   logic [KEY_WIDTH-1:0] fence_key_q, fence_key_d;
   logic                 fence_vld_q, fence_vld_d;

   // Read-after-write hazard: a search must not overtake an in-flight insert
   // to the same key, so it waits for the engine to drain completely.
   assign fence_block = fence_vld_q && (head_opcode == OP_SEARCH) &&
                        (head_key == fence_key_q) && (outs_q != '0);

   always_comb begin
      fence_key_d = fence_key_q;
      fence_vld_d = fence_vld_q;
      if (go && (head_opcode == OP_INSERT)) begin
         fence_key_d = head_key;
         fence_vld_d = 1'b1;
      end else if (outs_d == '0) begin
         fence_vld_d = 1'b0;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         fence_key_q <= '0;
         fence_vld_q <= 1'b0;
      end else begin
         fence_key_q <= fence_key_d;
         fence_vld_q <= fence_vld_d;
      end
   end
`else
   assign fence_block = 1'b0;
`endif

   always_comb begin
      // Held low during reset so the host never sees a stale "ready".
      in_ready = !reset && (count_q != FULL_CNT);
      store    = in_valid && in_ready && (in_opcode != OP_NOP);
      // An entry written this cycle is not counted yet, so there is no bypass.
      go       = (count_q != '0) && !pe_stall && (outs_q < OUTS_CAP) && !fence_block;
      // A completion with nothing in flight is ignored.
      retire   = pe_output_valid && (outs_q != '0);

      wr_ptr_d = store ? wr_ptr_q + PW'(1) : wr_ptr_q;
      rd_ptr_d = go    ? rd_ptr_q + PW'(1) : rd_ptr_q;

      count_d = count_q;
      case ({store, go})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase

      outs_d = outs_q;
      case ({go, retire})
         2'b10:   outs_d = outs_q + OW'(1);
         2'b01:   outs_d = outs_q - OW'(1);
         default: outs_d = outs_q;
      endcase

      pe_valid_d   = go;
      pe_opcode_d  = go ? head_opcode  : '0;
      pe_key_d     = go ? head_key     : '0;
      pe_wr_data_d = go ? head_wr_data : '0;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         outs_q       <= '0;
         pe_valid_q   <= 1'b0;
         pe_opcode_q  <= '0;
         pe_key_q     <= '0;
         pe_wr_data_q <= '0;
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         outs_q       <= outs_d;
         pe_valid_q   <= pe_valid_d;
         pe_opcode_q  <= pe_opcode_d;
         pe_key_q     <= pe_key_d;
         pe_wr_data_q <= pe_wr_data_d;
      end
   end

   // Storage is not reset; occupancy alone decides which entries are live.
   always_ff @(posedge clock) begin
      if (store) begin
         mem_q[wr_ptr_q] <= {in_opcode, in_key, in_wr_data};
      end
   end

   assign pe_input_valid = pe_valid_q;
   assign pe_opcode      = pe_opcode_q;
   assign pe_key         = pe_key_q;
   assign pe_wr_data     = pe_wr_data_q;
   assign occupancy      = count_q;
   assign outstanding    = outs_q;

endmodule
